// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS31 (x^31 + x^28 + 1) word-parallel checker:
// checker state encoding, polynomial taps and the one-word state advance.
package prbs_pkg;

    localparam int PRBS_WIDTH = 31;
    localparam int TAP_HI     = 31;
    localparam int TAP_LO     = 28;
    localparam int TAP_GAP    = TAP_HI - TAP_LO;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    typedef logic [PRBS_WIDTH-1:0] prbs_word_t;

    // Advances the register by a full word (31 bit times); the low bits feed
    // on the freshly computed high bits, so the order of the two lines matters.
    function automatic prbs_word_t prbs_next(input prbs_word_t s);
        prbs_word_t n;
        n = '0;
        n[PRBS_WIDTH-1:TAP_GAP] = s[PRBS_WIDTH-1:TAP_GAP] ^ s[TAP_LO-1:0];
        n[TAP_GAP-1:0]          = s[TAP_GAP-1:0] ^ n[PRBS_WIDTH-1:TAP_LO];
        return n;
    endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of a 31-bit error vector.
module prbs_popcount (
    input  logic [30:0] vec_i,
    output logic [4:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 31; i++) begin
            count_o = count_o + 5'(vec_i[i]);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS31 word checker: seeds from the received word, verifies LOCK_CNT words,
// then flywheels while counting bit and word errors until LOSS_CNT misses in a row.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH    = 31,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] di,
    input  logic             valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             word_err,
    output logic             lock_lost,
    output logic [31:0]      err_cnt,
    output logic [31:0]      word_cnt,
    output logic [1:0]       dbg_state   // 0 SEARCH, 1 VERIFY, 2 LOCKED
);

    if (WIDTH != PRBS_WIDTH) begin : g_bad_width
        $error("prbs_checker: WIDTH must be 31");
    end
    if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock
        $error("prbs_checker: LOCK_CNT must be 1..15");
    end
    if (LOSS_CNT < 1 || LOSS_CNT > 15) begin : g_bad_loss
        $error("prbs_checker: LOSS_CNT must be 1..15");
    end

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    prbs_state_e state_q, state_d;
    prbs_word_t  lfsr_q, lfsr_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic        locked_q, locked_d;
    logic        word_err_q, word_err_d;
    logic        lock_lost_q, lock_lost_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] word_cnt_q, word_cnt_d;

    prbs_word_t  din, seed, nxt, exp_word;
    logic [4:0]  nbits;
    logic [32:0] err_sum;

    assign din      = di;
    assign seed     = ~din;
    assign nxt      = prbs_next(lfsr_q);
    assign exp_word = ~nxt;

    prbs_popcount u_popcount (
        .vec_i   (din ^ exp_word),
        .count_o (nbits)
    );

    assign err_sum = {1'b0, err_cnt_q} + {28'b0, nbits};

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        match_d     = match_q;
        miss_d      = miss_q;
        word_err_d  = 1'b0;
        lock_lost_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            ST_SEARCH: begin
                // An all-ones word would seed zero, which never advances.
                if (valid && seed != '0) begin
                    lfsr_d = seed;
                    if (LOCK_CNT == 1) begin
                        state_d = ST_LOCKED;
                        miss_d  = '0;
                    end else begin
                        state_d = ST_VERIFY;
                        match_d = 4'd1;
                    end
                end
            end
            ST_VERIFY: begin
                if (lfsr_q == '0) begin
                    state_d = ST_SEARCH;
                end else if (valid) begin
                    if (din == exp_word) begin
                        lfsr_d  = nxt;
                        match_d = match_q + 4'd1;
                        if (match_d >= LOCK_C) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                        match_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (lfsr_q == '0) begin
                    state_d = ST_SEARCH;
                end else if (valid) begin
                    lfsr_d     = nxt;
                    err_cnt_d  = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
                    word_cnt_d = (word_cnt_q == 32'hFFFF_FFFF) ? word_cnt_q
                                                               : word_cnt_q + 32'd1;
                    if (nbits != '0) begin
                        word_err_d = 1'b1;
                        miss_d     = miss_q + 4'd1;
                        if (miss_d == LOSS_C) begin
                            state_d     = ST_SEARCH;
                            lock_lost_d = 1'b1;
                            miss_d      = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        if (clr_cnt) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            lfsr_q      <= 31'h1;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            word_err_q  <= 1'b0;
            lock_lost_q <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            word_err_q  <= word_err_d;
            lock_lost_q <= lock_lost_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign word_err  = word_err_q;
    assign lock_lost = lock_lost_q;
    assign err_cnt   = err_cnt_q;
    assign word_cnt  = word_cnt_q;
    assign dbg_state = state_q;

endmodule
